udp_rx_port_demux: RTL and testbench

Receive-side counterpart of the UDP TX arbitration mux. It takes one UDP RX stream (header handshake plus AXI-Stream payload) from the UDP stack and steers each whole frame to one of M_COUNT application ports. The output is chosen by matching the UDP destination port against a parameter table. Frames whose destination port matches no entry are consumed and counted as drops. The block sits between the UDP RX path and per-application consumers.

---
 rtl/udp_rx_port_demux.sv | 172 +++++++++++++++++
 tb/tb_udp_rx_port_demux.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_rx_port_demux.sv
// udp_rx_port_demux: steers whole UDP RX frames to one of M_COUNT application
// ports by matching the destination port against a fixed table. Frames with
// no matching entry are swallowed and counted in drop_count.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | waiting for a header; payload input is held off
// FORWARD | payload of a matched frame flows combinationally to channel sel
// DROP    | payload of an unmatched frame is accepted and discarded
module udp_rx_port_demux #(
  parameter int                    M_COUNT    = 2,
  parameter logic [M_COUNT*16-1:0] M_PORTS    = {16'd1235, 16'd1234},
  parameter int                    DATA_WIDTH = 8,
  parameter int                    KEEP_WIDTH = DATA_WIDTH/8,
  parameter int                    USER_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,

  input  logic                  s_udp_hdr_valid,
  output logic                  s_udp_hdr_ready,
  input  logic [31:0]           s_ip_source_ip,
  input  logic [15:0]           s_udp_source_port,
  input  logic [15:0]           s_udp_dest_port,
  input  logic [15:0]           s_udp_length,
  input  logic [DATA_WIDTH-1:0] s_udp_payload_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_udp_payload_axis_tkeep,
  input  logic                  s_udp_payload_axis_tvalid,
  output logic                  s_udp_payload_axis_tready,
  input  logic                  s_udp_payload_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_udp_payload_axis_tuser,

  output logic [M_COUNT-1:0]    m_udp_hdr_valid,
  input  logic [M_COUNT-1:0]    m_udp_hdr_ready,
  output logic [31:0]           m_ip_source_ip,
  output logic [15:0]           m_udp_source_port,
  output logic [15:0]           m_udp_dest_port,
  output logic [15:0]           m_udp_length,
  output logic [DATA_WIDTH-1:0] m_udp_payload_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_udp_payload_axis_tkeep,
  output logic [M_COUNT-1:0]    m_udp_payload_axis_tvalid,
  input  logic [M_COUNT-1:0]    m_udp_payload_axis_tready,
  output logic                  m_udp_payload_axis_tlast,
  output logic [USER_WIDTH-1:0] m_udp_payload_axis_tuser,

  output logic [31:0]           drop_count
);

  localparam int SEL_W = (M_COUNT > 1) ? $clog2(M_COUNT) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FORWARD = 2'd1,
    DROP    = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [SEL_W-1:0]   sel;
  logic               hdr_pending;
  logic               match_found;
  logic [SEL_W-1:0]   match_idx;
  logic               hdr_accept;
  logic               beat_last;

  // Table lookup; scanning from the top down lets the lowest index win.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    for (int i = M_COUNT - 1; i >= 0; i--) begin
      if (s_udp_dest_port == M_PORTS[16*i +: 16]) begin
        match_found = 1'b1;
        match_idx   = SEL_W'(i);
      end
    end
  end

  // A new header is only taken once the previous one has left, and never
  // while reset is held (the async reset forces IDLE, which alone would
  // otherwise advertise ready).
  assign s_udp_hdr_ready = reset_n && (state == IDLE) && !hdr_pending;
  assign hdr_accept      = s_udp_hdr_valid && s_udp_hdr_ready;
  assign beat_last       = s_udp_payload_axis_tvalid && s_udp_payload_axis_tready &&
                           s_udp_payload_axis_tlast;

  // Payload sideband is a shared bus; only tvalid is steered per channel.
  assign m_udp_payload_axis_tdata = s_udp_payload_axis_tdata;
  assign m_udp_payload_axis_tkeep = s_udp_payload_axis_tkeep;
  assign m_udp_payload_axis_tlast = s_udp_payload_axis_tlast;
  assign m_udp_payload_axis_tuser = s_udp_payload_axis_tuser;

  // Header valid is a one-hot decode of the pending flag onto channel sel.
  always_comb begin
    m_udp_hdr_valid = '0;
    if (hdr_pending) begin
      m_udp_hdr_valid[sel] = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and payload steering.
  always_comb begin
    state_next                = state;
    s_udp_payload_axis_tready = 1'b0;
    m_udp_payload_axis_tvalid = '0;
    case (state)
      IDLE: begin
        if (hdr_accept) begin
          state_next = match_found ? FORWARD : DROP;
        end
      end
      FORWARD: begin
        m_udp_payload_axis_tvalid[sel] = s_udp_payload_axis_tvalid;
        s_udp_payload_axis_tready      = m_udp_payload_axis_tready[sel];
        if (beat_last) begin
          state_next = IDLE;
        end
      end
      DROP: begin
        s_udp_payload_axis_tready = 1'b1;
        if (beat_last) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Header capture, channel select and pending flag. The pending flag is
  // independent of the payload so data may run ahead of a stalled header.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel               <= '0;
      hdr_pending       <= 1'b0;
      m_ip_source_ip    <= '0;
      m_udp_source_port <= '0;
      m_udp_dest_port   <= '0;
      m_udp_length      <= '0;
    end else begin
      if (hdr_accept && match_found) begin
        sel               <= match_idx;
        hdr_pending       <= 1'b1;
        m_ip_source_ip    <= s_ip_source_ip;
        m_udp_source_port <= s_udp_source_port;
        m_udp_dest_port   <= s_udp_dest_port;
        m_udp_length      <= s_udp_length;
      end else if (hdr_pending && m_udp_hdr_ready[sel]) begin
        hdr_pending <= 1'b0;
      end
    end
  end

  // Unmatched frame counter, free-running wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drop_count <= '0;
    end else if (hdr_accept && !match_found) begin
      drop_count <= drop_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_udp_rx_port_demux.sv
// Directed bench for udp_rx_port_demux with the default two-entry table
// (channel 0 = port 1234, channel 1 = port 1235).
module tb_udp_rx_port_demux;

  logic        clk;
  logic        reset_n;
  logic        s_hdr_valid;
  logic        s_hdr_ready;
  logic [31:0] s_ip;
  logic [15:0] s_sport;
  logic [15:0] s_dport;
  logic [15:0] s_len;
  logic [7:0]  s_tdata;
  logic [0:0]  s_tkeep;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic [0:0]  s_tuser;
  logic [1:0]  m_hdr_valid;
  logic [1:0]  m_hdr_ready;
  logic [31:0] m_ip;
  logic [15:0] m_sport;
  logic [15:0] m_dport;
  logic [15:0] m_len;
  logic [7:0]  m_tdata;
  logic [0:0]  m_tkeep;
  logic [1:0]  m_tvalid;
  logic [1:0]  m_tready;
  logic        m_tlast;
  logic [0:0]  m_tuser;
  logic [31:0] drop_count;

  int errors = 0;
  int checks = 0;

  // Monitor state: delivered beats {tlast, tdata}, delivered headers
  // {source_port, dest_port}, and protocol-violation counters.
  logic [8:0]  q0[$];
  logic [8:0]  q1[$];
  logic [31:0] hq0[$];
  logic [31:0] hq1[$];
  int          exp_ch = -1;
  int          wrong_cnt = 0;
  int          onehot_err = 0;
  int          pt_err = 0;

  udp_rx_port_demux dut (
    .clk                       (clk),
    .reset_n                   (reset_n),
    .s_udp_hdr_valid           (s_hdr_valid),
    .s_udp_hdr_ready           (s_hdr_ready),
    .s_ip_source_ip            (s_ip),
    .s_udp_source_port         (s_sport),
    .s_udp_dest_port           (s_dport),
    .s_udp_length              (s_len),
    .s_udp_payload_axis_tdata  (s_tdata),
    .s_udp_payload_axis_tkeep  (s_tkeep),
    .s_udp_payload_axis_tvalid (s_tvalid),
    .s_udp_payload_axis_tready (s_tready),
    .s_udp_payload_axis_tlast  (s_tlast),
    .s_udp_payload_axis_tuser  (s_tuser),
    .m_udp_hdr_valid           (m_hdr_valid),
    .m_udp_hdr_ready           (m_hdr_ready),
    .m_ip_source_ip            (m_ip),
    .m_udp_source_port         (m_sport),
    .m_udp_dest_port           (m_dport),
    .m_udp_length              (m_len),
    .m_udp_payload_axis_tdata  (m_tdata),
    .m_udp_payload_axis_tkeep  (m_tkeep),
    .m_udp_payload_axis_tvalid (m_tvalid),
    .m_udp_payload_axis_tready (m_tready),
    .m_udp_payload_axis_tlast  (m_tlast),
    .m_udp_payload_axis_tuser  (m_tuser),
    .drop_count                (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample mid-cycle what the next rising edge will see.
  always @(negedge clk) begin
    #2;
    if (reset_n) begin
      for (int c = 0; c < 2; c++) begin
        if (m_tvalid[c] && m_tready[c]) begin
          if (c == 0) q0.push_back({m_tlast, m_tdata});
          else        q1.push_back({m_tlast, m_tdata});
        end
        if (m_tvalid[c] && c != exp_ch) wrong_cnt++;
        if (m_hdr_valid[c] && m_hdr_ready[c]) begin
          if (c == 0) hq0.push_back({m_sport, m_dport});
          else        hq1.push_back({m_sport, m_dport});
        end
      end
      if ($countones(m_hdr_valid) > 1 || $countones(m_tvalid) > 1) onehot_err++;
      if (m_tvalid != 2'b00 && (m_tkeep !== s_tkeep || m_tuser !== s_tuser)) pt_err++;
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_hdr(input logic [15:0] dp, input logic [31:0] ip,
                          input logic [15:0] sp, input logic [15:0] len);
    int g;
    g = 0;
    s_hdr_valid = 1'b1;
    s_dport = dp;
    s_ip = ip;
    s_sport = sp;
    s_len = len;
    #1;
    while (!s_hdr_ready && g < 20) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (g >= 20) begin
      errors++;
      checks++;
      $display("FAIL hdr_accept_timeout: dest_port=%0d never accepted", dp);
    end
    @(negedge clk);
    s_hdr_valid = 1'b0;
  endtask

  // Called at a falling edge; sends n beats base, base+1, ... with tlast on the last.
  task automatic send_payload(input int n, input logic [7:0] base);
    int g;
    for (int b = 0; b < n; b++) begin
      s_tdata = base + 8'(b);
      s_tlast = (b == n - 1);
      s_tvalid = 1'b1;
      g = 0;
      #1;
      while (!s_tready && g < 50) begin
        @(negedge clk);
        #1;
        g++;
      end
      if (g >= 50) begin
        errors++;
        checks++;
        $display("FAIL payload_timeout: beat %0d never accepted", b);
      end
      @(negedge clk);
    end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    s_hdr_valid = 1'b0;
    s_ip = '0;
    s_sport = '0;
    s_dport = '0;
    s_len = '0;
    s_tdata = '0;
    s_tkeep = 1'b1;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    s_tuser = 1'b0;
    m_hdr_ready = 2'b11;
    m_tready = 2'b11;
    #12;
    checks++; if (s_hdr_ready !== 1'b0) begin errors++; $display("FAIL rst_hdr_ready: got %b want 0", s_hdr_ready); end
    checks++; if (m_hdr_valid !== 2'b00) begin errors++; $display("FAIL rst_hdr_valid: got %b want 00", m_hdr_valid); end
    checks++; if (m_tvalid !== 2'b00) begin errors++; $display("FAIL rst_tvalid: got %b want 00", m_tvalid); end
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL rst_s_tready: got %b want 0", s_tready); end
    checks++; if (drop_count !== 32'd0) begin errors++; $display("FAIL rst_drop_count: got %0d want 0", drop_count); end
    checks++; if (m_dport !== 16'd0 || m_ip !== 32'd0) begin errors++; $display("FAIL rst_hdr_fields: got %0h/%0h want 0/0", m_dport, m_ip); end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (s_hdr_ready !== 1'b1) begin errors++; $display("FAIL post_rst_hdr_ready: got %b want 1", s_hdr_ready); end
    @(negedge clk);
  endtask

  task automatic test_port_match;
    int b0, b1, w0;
    b0 = q0.size(); b1 = q1.size(); w0 = wrong_cnt;
    exp_ch = 0;
    send_hdr(16'd1234, 32'h0A000001, 16'd4000, 16'd12);
    checks++; if (m_hdr_valid !== 2'b01) begin errors++; $display("FAIL match_hdr_valid: got %b want 01", m_hdr_valid); end
    checks++; if (m_dport !== 16'd1234 || m_sport !== 16'd4000) begin errors++; $display("FAIL match_hdr_fields: got %0d/%0d want 1234/4000", m_dport, m_sport); end
    send_payload(4, 8'h11);
    #1;
    checks++; if (s_hdr_ready !== 1'b1) begin errors++; $display("FAIL match_back_to_idle: hdr_ready got %b want 1", s_hdr_ready); end
    checks++;
    if (q0.size() != b0 + 4) begin
      errors++; $display("FAIL match_beat_count: got %0d want 4", q0.size() - b0);
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (q0[b0+k] !== {(k == 3), 8'h11 + 8'(k)}) begin
          errors++; $display("FAIL match_beat%0d: got %0h want %0h", k, q0[b0+k], {(k == 3), 8'h11 + 8'(k)});
        end
      end
    end
    checks++; if (q1.size() != b1 || wrong_cnt != w0) begin errors++; $display("FAIL match_ch1_quiet: ch1 beats %0d stray valids %0d want 0/0", q1.size() - b1, wrong_cnt - w0); end
    @(negedge clk);
  endtask

  task automatic test_drop;
    int b0, b1, w0;
    b0 = q0.size(); b1 = q1.size(); w0 = wrong_cnt;
    exp_ch = -1;
    for (int f = 0; f < 2; f++) begin
      send_hdr(16'd80, 32'h0A000009, 16'd999, 16'd11);
      checks++; if (m_hdr_valid !== 2'b00) begin errors++; $display("FAIL drop_hdr_valid: got %b want 00", m_hdr_valid); end
      for (int b = 0; b < 3; b++) begin
        s_tvalid = 1'b1;
        s_tdata = 8'hD0 + 8'(b);
        s_tlast = (b == 2);
        #1;
        checks++; if (s_tready !== 1'b1) begin errors++; $display("FAIL drop_s_tready beat%0d: got %b want 1", b, s_tready); end
        @(negedge clk);
      end
      s_tvalid = 1'b0;
      s_tlast = 1'b0;
      checks++; if (drop_count !== 32'(f + 1)) begin errors++; $display("FAIL drop_count: got %0d want %0d", drop_count, f + 1); end
      #1;
      checks++; if (s_hdr_ready !== 1'b1) begin errors++; $display("FAIL drop_back_to_idle: got %b want 1", s_hdr_ready); end
      @(negedge clk);
    end
    checks++; if (q0.size() != b0 || q1.size() != b1 || wrong_cnt != w0) begin errors++; $display("FAIL drop_leak: beats %0d/%0d stray %0d want 0/0/0", q0.size() - b0, q1.size() - b1, wrong_cnt - w0); end
  endtask

  task automatic test_hdr_backpressure;
    int b0, b1, h1;
    b0 = q0.size(); b1 = q1.size(); h1 = hq1.size();
    exp_ch = 1;
    m_hdr_ready = 2'b01;
    send_hdr(16'd1235, 32'hC0A80001, 16'd5000, 16'd12);
    checks++; if (m_hdr_valid !== 2'b10) begin errors++; $display("FAIL hbp_hdr_valid: got %b want 10", m_hdr_valid); end
    send_payload(4, 8'h30);
    checks++; if (m_hdr_valid !== 2'b10) begin errors++; $display("FAIL hbp_hdr_held: got %b want 10", m_hdr_valid); end
    checks++;
    if (m_dport !== 16'd1235 || m_ip !== 32'hC0A80001 || m_sport !== 16'd5000 || m_len !== 16'd12) begin
      errors++; $display("FAIL hbp_fields: got %0d %0h %0d %0d want 1235 c0a80001 5000 12", m_dport, m_ip, m_sport, m_len);
    end
    s_hdr_valid = 1'b1;
    s_dport = 16'd1234;
    s_sport = 16'd7;
    s_ip = 32'h0A000002;
    s_len = 16'd9;
    #1;
    checks++; if (s_hdr_ready !== 1'b0) begin errors++; $display("FAIL hbp_next_blocked0: got %b want 0", s_hdr_ready); end
    @(negedge clk);
    #1;
    checks++; if (s_hdr_ready !== 1'b0) begin errors++; $display("FAIL hbp_next_blocked1: got %b want 0", s_hdr_ready); end
    checks++; if (m_dport !== 16'd1235) begin errors++; $display("FAIL hbp_stable: got %0d want 1235", m_dport); end
    m_hdr_ready[1] = 1'b1;
    @(negedge clk);
    m_hdr_ready[1] = 1'b0;
    #1;
    checks++; if (s_hdr_ready !== 1'b1) begin errors++; $display("FAIL hbp_released: got %b want 1", s_hdr_ready); end
    @(negedge clk);
    s_hdr_valid = 1'b0;
    checks++; if (m_hdr_valid !== 2'b01 || m_dport !== 16'd1234) begin errors++; $display("FAIL hbp_second_hdr: got %b/%0d want 01/1234", m_hdr_valid, m_dport); end
    exp_ch = 0;
    send_payload(1, 8'h55);
    m_hdr_ready = 2'b11;
    checks++;
    if (q1.size() != b1 + 4) begin
      errors++; $display("FAIL hbp_ch1_count: got %0d want 4", q1.size() - b1);
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (q1[b1+k] !== {(k == 3), 8'h30 + 8'(k)}) begin
          errors++; $display("FAIL hbp_ch1_beat%0d: got %0h want %0h", k, q1[b1+k], {(k == 3), 8'h30 + 8'(k)});
        end
      end
    end
    checks++; if (q0.size() != b0 + 1 || q0[q0.size()-1] !== 9'h155) begin errors++; $display("FAIL hbp_ch0_beat: count %0d want 1", q0.size() - b0); end
    checks++; if (hq1.size() != h1 + 1 || hq1[hq1.size()-1] !== {16'd5000, 16'd1235}) begin errors++; $display("FAIL hbp_hdr_delivered: count %0d want 1", hq1.size() - h1); end
    @(negedge clk);
  endtask

  task automatic test_payload_backpressure;
    int b0, beat, g;
    logic tog;
    b0 = q0.size();
    exp_ch = 0;
    m_tready = 2'b11;
    send_hdr(16'd1234, 32'h0A000003, 16'd6000, 16'd16);
    beat = 0;
    g = 0;
    tog = 1'b1;
    while (beat < 8 && g < 40) begin
      m_tready[0] = tog;
      tog = ~tog;
      s_tvalid = 1'b1;
      s_tdata = 8'h20 + 8'(beat);
      s_tlast = (beat == 7);
      #1;
      checks++; if (s_tready !== m_tready[0]) begin errors++; $display("FAIL pbp_mirror: s_tready %b ch0 tready %b", s_tready, m_tready[0]); end
      if (m_tready[0]) beat++;
      @(negedge clk);
      g++;
    end
    if (g >= 40) begin errors++; checks++; $display("FAIL pbp_timeout: %0d beats sent", beat); end
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    m_tready[0] = 1'b1;
    checks++;
    if (q0.size() != b0 + 8) begin
      errors++; $display("FAIL pbp_count: got %0d want 8", q0.size() - b0);
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (q0[b0+k] !== {(k == 7), 8'h20 + 8'(k)}) begin
          errors++; $display("FAIL pbp_beat%0d: got %0h want %0h", k, q0[b0+k], {(k == 7), 8'h20 + 8'(k)});
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [15:0] ports [3] = '{16'd1234, 16'd1235, 16'd1234};
    logic [15:0] sps   [3] = '{16'd101, 16'd102, 16'd103};
    logic [7:0]  dat   [3] = '{8'hA1, 8'hA2, 8'hA3};
    int          chs   [3] = '{0, 1, 0};
    logic [1:0]  want_v;
    int b0, b1, h0, h1, w0;
    b0 = q0.size(); b1 = q1.size(); h0 = hq0.size(); h1 = hq1.size(); w0 = wrong_cnt;
    for (int k = 0; k < 3; k++) begin
      exp_ch = chs[k];
      want_v = (chs[k] == 0) ? 2'b01 : 2'b10;
      send_hdr(ports[k], 32'h0A000010 + 32'(k), sps[k], 16'd9);
      checks++; if (m_hdr_valid !== want_v || m_sport !== sps[k]) begin errors++; $display("FAIL b2b_hdr%0d: got %b/%0d want %b/%0d", k, m_hdr_valid, m_sport, want_v, sps[k]); end
      send_payload(1, dat[k]);
    end
    checks++; if (q0.size() != b0 + 2 || q0[b0] !== 9'h1A1 || q0[b0+1] !== 9'h1A3) begin errors++; $display("FAIL b2b_ch0: count %0d want 2 (a1,a3)", q0.size() - b0); end
    checks++; if (q1.size() != b1 + 1 || q1[b1] !== 9'h1A2) begin errors++; $display("FAIL b2b_ch1: count %0d want 1 (a2)", q1.size() - b1); end
    checks++;
    if (hq0.size() != h0 + 2 || hq1.size() != h1 + 1 || hq0[h0] !== {16'd101, 16'd1234} ||
        hq0[h0+1] !== {16'd103, 16'd1234} || hq1[h1] !== {16'd102, 16'd1235}) begin
      errors++; $display("FAIL b2b_headers: ch0 %0d ch1 %0d headers want 2/1", hq0.size() - h0, hq1.size() - h1);
    end
    checks++; if (wrong_cnt != w0) begin errors++; $display("FAIL b2b_misroute: got %0d stray valids want 0", wrong_cnt - w0); end
    checks++; if (onehot_err != 0 || pt_err != 0) begin errors++; $display("FAIL onehot_passthru: onehot %0d passthru %0d want 0/0", onehot_err, pt_err); end
  endtask

  task automatic test_reset_mid_frame;
    int b0, b1;
    b0 = q0.size(); b1 = q1.size();
    exp_ch = 0;
    send_hdr(16'd1234, 32'h0A000020, 16'd8000, 16'd12);
    for (int b = 0; b < 2; b++) begin
      s_tvalid = 1'b1;
      s_tdata = 8'h61 + 8'(b);
      s_tlast = 1'b0;
      @(negedge clk);
    end
    s_tdata = 8'h63;
    #1;
    reset_n = 1'b0;
    #1;
    checks++; if (m_tvalid !== 2'b00 || m_hdr_valid !== 2'b00) begin errors++; $display("FAIL mid_rst_valids: tvalid %b hdr_valid %b want 00/00", m_tvalid, m_hdr_valid); end
    checks++; if (drop_count !== 32'd0) begin errors++; $display("FAIL mid_rst_drop_count: got %0d want 0", drop_count); end
    checks++; if (s_tready !== 1'b0 || s_hdr_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_readies: s_tready %b hdr_ready %b want 0/0", s_tready, s_hdr_ready); end
    @(negedge clk);
    s_tvalid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    exp_ch = 1;
    send_hdr(16'd1235, 32'h0A000021, 16'd8001, 16'd9);
    checks++; if (m_hdr_valid !== 2'b10 || m_dport !== 16'd1235) begin errors++; $display("FAIL mid_rst_recover_hdr: got %b/%0d want 10/1235", m_hdr_valid, m_dport); end
    send_payload(1, 8'h70);
    checks++; if (q1.size() != b1 + 1 || q1[q1.size()-1] !== 9'h170 || q0.size() != b0 + 2) begin errors++; $display("FAIL mid_rst_beats: ch0 %0d ch1 %0d want 2/1", q0.size() - b0, q1.size() - b1); end
  endtask

  initial begin
    test_reset();
    test_port_match();
    test_drop();
    test_hdr_backpressure();
    test_payload_backpressure();
    test_back_to_back();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
